vga_write_arbiter: RTL and testbench

Shares the single VGA frame-buffer write port between the game's drawing engines: the tower placer, the enemy/car renderer and the background/HUD painter. Each engine requests the port and holds it for a whole drawing burst, e.g. a square, tower or erase. The block picks the owner round-robin and forwards only the owner's pixel writes, registered. It clips off-screen pixels and counts them. It sits between the engine datapaths and the VGA adapter's `writeEn/x/y/colour` inputs.

---
 rtl/vga_pkg.sv | 23 ++
 rtl/vga_write_arbiter_rr_pick.sv | 33 +++
 rtl/vga_write_arbiter.sv | 143 ++++++++++++++
 tb/tb_vga_write_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_pkg: shared frame-buffer widths, screen size and arbiter states |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
package vga_pkg;

  localparam int COORD_W  = 15;
  localparam int COLOUR_W = 9;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN  = 2'd1,
    GAP  = 2'd2
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/vga_write_arbiter_rr_pick.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rr_pick: combinational round-robin pick, first request after last  |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module rr_pick #(
  parameter int N  = 3,
  parameter int LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] sel,
  output logic          any
);

  logic [LW-1:0] w_idx;

  // Walk the ring starting one past the previous winner; first hit wins.
  always_comb begin
    sel   = '0;
    any   = 1'b0;
    w_idx = last;
    for (int k = 0; k < N; k++) begin
      w_idx = (w_idx == LW'(N - 1)) ? '0 : w_idx + 1'b1;
      if (!any && req[w_idx]) begin
        any = 1'b1;
        sel = w_idx;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/vga_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | vga_write_arbiter: round-robin owner of the VGA write port, with   |
// | registered forwarding, off-screen clipping and a clip counter.     |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module vga_write_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ = 3,
  parameter int X_MAX = SCREEN_W,
  parameter int Y_MAX = SCREEN_H
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ-1:0]          wr_en,
  input  logic [COORD_W*N_REQ-1:0]  wr_coords,
  input  logic [COLOUR_W*N_REQ-1:0] wr_colour,
  output logic [N_REQ-1:0]          grant,
  output logic                      vga_WriteEn,
  output logic [COORD_W-1:0]        vga_coords,
  output logic [COLOUR_W-1:0]       vga_colour,
  output logic                      busy,
  output logic [15:0]               clip_count
);

  localparam int LW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int XLW = X_W + 1;
  localparam int YLW = Y_W + 1;
  localparam logic [XLW-1:0] c_X_LIM    = XLW'(X_MAX);
  localparam logic [YLW-1:0] c_Y_LIM    = YLW'(Y_MAX);
  localparam logic [15:0]    c_CLIP_MAX = 16'hFFFF;

  arb_state_t           r_state, w_state_nxt;
  logic [N_REQ-1:0]     r_grant, w_grant_nxt;
  logic [LW-1:0]        r_last, w_last_nxt;
  logic                 r_vga_we;
  logic [COORD_W-1:0]   r_vga_coords;
  logic [COLOUR_W-1:0]  r_vga_colour;
  logic [15:0]          r_clip_count;

  logic [LW-1:0]        w_sel;
  logic                 w_any;
  logic                 w_own;
  logic                 w_own_en;
  logic                 w_own_req;
  logic [COORD_W-1:0]   w_own_coords;
  logic [COLOUR_W-1:0]  w_own_colour;
  logic [X_W-1:0]       w_x;
  logic [Y_W-1:0]       w_y;
  logic                 w_v;
  logic                 w_in;

  rr_pick #(
    .N  (N_REQ),
    .LW (LW)
  ) u_rr_pick (
    .req  (req),
    .last (r_last),
    .sel  (w_sel),
    .any  (w_any)
  );

  // While a burst is running, r_last is the owner index.
  always_comb begin
    w_own_en     = 1'b0;
    w_own_req    = 1'b0;
    w_own_coords = '0;
    w_own_colour = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (LW'(i) == r_last) begin
        w_own_en     = wr_en[i];
        w_own_req    = req[i];
        w_own_coords = wr_coords[i*COORD_W +: COORD_W];
        w_own_colour = wr_colour[i*COLOUR_W +: COLOUR_W];
      end
    end
  end

  assign w_own = (r_state == OWN);
  assign w_x   = w_own_coords[COORD_W-1:Y_W];
  assign w_y   = w_own_coords[Y_W-1:0];
  assign w_v   = w_own & w_own_en;
  assign w_in  = ({1'b0, w_x} < c_X_LIM) & ({1'b0, w_y} < c_Y_LIM);

  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    case (r_state)
      OWN: begin
        if (!w_own_req) begin
          w_state_nxt = GAP;
          w_grant_nxt = '0;
        end
      end
      default: begin
        w_grant_nxt = '0;
        if (w_any) begin
          w_state_nxt        = OWN;
          w_grant_nxt[w_sel] = 1'b1;
          w_last_nxt         = w_sel;
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= IDLE;
      r_grant      <= '0;
      r_last       <= LW'(N_REQ - 1);
      r_vga_we     <= 1'b0;
      r_vga_coords <= '0;
      r_vga_colour <= '0;
      r_clip_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_last   <= w_last_nxt;
      r_vga_we <= w_v & w_in;
      if (w_own) begin
        r_vga_coords <= w_own_coords;
        r_vga_colour <= w_own_colour;
      end
      if (w_v && !w_in && (r_clip_count != c_CLIP_MAX)) begin
        r_clip_count <= r_clip_count + 16'd1;
      end
    end
  end

  assign grant       = r_grant;
  assign vga_WriteEn = r_vga_we;
  assign vga_coords  = r_vga_coords;
  assign vga_colour  = r_vga_colour;
  assign busy        = w_own;
  assign clip_count  = r_clip_count;

endmodule
`default_nettype wire

// File: tb/tb_vga_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_vga_write_arbiter: vector table, corner sequences and random    |
// | traffic against a behavioural model of the arbiter.                |
// | Revision: 1.0                                                       |
// +--------------------------------------------------------------------+
module tb_vga_write_arbiter;

  localparam int N = 3;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req, wr_en;
  logic [44:0] wr_coords;
  logic [26:0] wr_colour;
  logic [2:0]  grant;
  logic        vga_WriteEn;
  logic [14:0] vga_coords;
  logic [8:0]  vga_colour;
  logic        busy;
  logic [15:0] clip_count;

  int checks   = 0;
  int failures = 0;

  // Model state: 0 = no owner (idle), 1 = owned, 2 = gap.
  int          m_state, m_owner, m_last, m_clip;
  logic [2:0]  m_grant;
  logic        m_we;
  logic [14:0] m_coords;
  logic [8:0]  m_colour;

  typedef struct {
    logic [2:0]  rq, en;
    logic [14:0] c0, c1, c2;
    logic [8:0]  k0, k1, k2;
    logic [2:0]  eg;
    logic        ewe;
    logic [14:0] ec;
    logic [8:0]  ek;
    logic [15:0] eclip;
  } vec_t;

  vec_t tbl[$];

  vga_write_arbiter dut (
    .clk         (clk),
    .resetn      (resetn),
    .req         (req),
    .wr_en       (wr_en),
    .wr_coords   (wr_coords),
    .wr_colour   (wr_colour),
    .grant       (grant),
    .vga_WriteEn (vga_WriteEn),
    .vga_coords  (vga_coords),
    .vga_colour  (vga_colour),
    .busy        (busy),
    .clip_count  (clip_count)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] pc(input int x, input int y);
    logic [31:0] xv, yv;
    xv = x;
    yv = y;
    return {xv[7:0], yv[6:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic set_px(input int i, input int x, input int y, input logic [8:0] col);
    wr_coords[15*i +: 15] = pc(x, y);
    wr_colour[9*i +: 9]   = col;
  endtask

  task automatic model_reset();
    m_state  = 0;
    m_owner  = 0;
    m_last   = N - 1;
    m_grant  = '0;
    m_we     = 1'b0;
    m_coords = '0;
    m_colour = '0;
    m_clip   = 0;
  endtask

  task automatic model_edge();
    int x, y;
    logic v;
    m_we = 1'b0;
    if (m_state == 1) begin
      x = int'(wr_coords[15*m_owner+7 +: 8]);
      y = int'(wr_coords[15*m_owner +: 7]);
      v = wr_en[m_owner];
      m_we     = v && (x < 160) && (y < 120);
      m_coords = wr_coords[15*m_owner +: 15];
      m_colour = wr_colour[9*m_owner +: 9];
      if (v && !(x < 160 && y < 120) && m_clip < 65535) m_clip++;
    end
    if (m_state == 1) begin
      if (!req[m_owner]) begin
        m_state = 2;
        m_grant = '0;
      end
    end else begin
      m_state = 0;
      m_grant = '0;
      for (int k = 1; k <= N; k++) begin
        if (m_state == 0 && req[(m_last + k) % N]) begin
          m_state = 1;
          m_owner = (m_last + k) % N;
          m_last  = m_owner;
          m_grant = 3'(1 << m_owner);
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".grant"},  64'(grant),       64'(m_grant));
    chk({tag, ".we"},     64'(vga_WriteEn), 64'(m_we));
    chk({tag, ".coords"}, 64'(vga_coords),  64'(m_coords));
    chk({tag, ".colour"}, 64'(vga_colour),  64'(m_colour));
    chk({tag, ".busy"},   64'(busy),        64'(m_state == 1));
    chk({tag, ".clip"},   64'(clip_count),  64'(m_clip));
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Called one time unit after a rising edge, so reset edges stay off the clock.
  task automatic reset_dut();
    req = '0; wr_en = '0; wr_coords = '0; wr_colour = '0;
    resetn = 1'b0;
    #2;
    model_reset();
    resetn = 1'b1;
    #1;
  endtask

  function automatic vec_t mk(input logic [2:0] rq, input logic [2:0] en,
                              input logic [14:0] c0, input logic [14:0] c1, input logic [14:0] c2,
                              input logic [8:0] k0, input logic [8:0] k1, input logic [8:0] k2,
                              input logic [2:0] eg, input logic ewe, input logic [14:0] ec,
                              input logic [8:0] ek, input logic [15:0] eclip);
    vec_t r;
    r.rq = rq; r.en = en; r.c0 = c0; r.c1 = c1; r.c2 = c2;
    r.k0 = k0; r.k1 = k1; r.k2 = k2;
    r.eg = eg; r.ewe = ewe; r.ec = ec; r.ek = ek; r.eclip = eclip;
    return r;
  endfunction

  initial begin
    int rr_req[13]   = '{7, 7, 7, 6, 7, 7, 7, 5, 7, 7, 7, 3, 7};
    int rr_grant[13] = '{1, 1, 1, 0, 2, 2, 2, 0, 4, 4, 4, 0, 1};

    // Burst by requester 1, clipping, final write on release, non-owner strobe.
    tbl.push_back(mk(3'b010, 3'b000, 0, pc(10, 5), 0, 0, 9'h1C0, 0, 3'b010, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(3'b010, 3'b010, 0, pc(10 + i, 5), 0, 0, 9'h1C0, 0,
                       3'b010, 1, pc(10 + i, 5), 9'h1C0, 0));
    tbl.push_back(mk(3'b010, 3'b010, 0, pc(160, 0), 0, 0, 9'h1C0, 0, 3'b010, 0, pc(160, 0), 9'h1C0, 1));
    tbl.push_back(mk(3'b010, 3'b010, 0, pc(0, 120), 0, 0, 9'h1C0, 0, 3'b010, 0, pc(0, 120), 9'h1C0, 2));
    tbl.push_back(mk(3'b010, 3'b010, 0, pc(159, 119), 0, 0, 9'h1C0, 0, 3'b010, 1, pc(159, 119), 9'h1C0, 2));
    tbl.push_back(mk(3'b000, 3'b010, 0, pc(20, 30), 0, 0, 9'h055, 0, 3'b000, 1, pc(20, 30), 9'h055, 2));
    tbl.push_back(mk(3'b000, 3'b010, 0, pc(40, 40), 0, 0, 9'h0AA, 0, 3'b000, 0, pc(20, 30), 9'h055, 2));
    tbl.push_back(mk(3'b001, 3'b100, pc(1, 2), 0, pc(200, 0), 9'h003, 0, 9'h1FF, 3'b001, 0, pc(20, 30), 9'h055, 2));
    tbl.push_back(mk(3'b001, 3'b100, pc(1, 2), 0, pc(200, 0), 9'h003, 0, 9'h1FF, 3'b001, 0, pc(1, 2), 9'h003, 2));

    // Power-on reset, then asynchronous reset in the middle of a burst.
    resetn = 1'b0;
    req = '0; wr_en = '0; wr_coords = '0; wr_colour = '0;
    model_reset();
    #12;
    resetn = 1'b1;
    #1;
    check_model("por");
    req = 3'b010;
    step("rst_a");
    wr_en = 3'b010;
    set_px(1, 50, 60, 9'h0F0);
    step("rst_b");
    #2;
    resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst.grant",  64'(grant),       64'(0));
    chk("async_rst.we",     64'(vga_WriteEn), 64'(0));
    chk("async_rst.coords", 64'(vga_coords),  64'(0));
    chk("async_rst.colour", 64'(vga_colour),  64'(0));
    chk("async_rst.busy",   64'(busy),        64'(0));
    chk("async_rst.clip",   64'(clip_count),  64'(0));
    resetn = 1'b1;
    req = 3'b111; wr_en = '0;
    step("rst_first");
    chk("rst_first_grant", 64'(grant), 64'(3'b001));

    // Vector table.
    #1;
    reset_dut();
    foreach (tbl[i]) begin
      req = tbl[i].rq;
      wr_en = tbl[i].en;
      wr_coords = {tbl[i].c2, tbl[i].c1, tbl[i].c0};
      wr_colour = {tbl[i].k2, tbl[i].k1, tbl[i].k0};
      step($sformatf("vec%0d", i));
      chk($sformatf("vec%0d.grant", i),  64'(grant),       64'(tbl[i].eg));
      chk($sformatf("vec%0d.we", i),     64'(vga_WriteEn), 64'(tbl[i].ewe));
      chk($sformatf("vec%0d.coords", i), 64'(vga_coords),  64'(tbl[i].ec));
      chk($sformatf("vec%0d.colour", i), 64'(vga_colour),  64'(tbl[i].ek));
      chk($sformatf("vec%0d.clip", i),   64'(clip_count),  64'(tbl[i].eclip));
    end

    // Round-robin rotation with one dead cycle between owners.
    #1;
    reset_dut();
    for (int i = 0; i < 13; i++) begin
      req = 3'(rr_req[i]);
      step($sformatf("rr%0d", i));
      chk($sformatf("rr%0d.grant", i), 64'(grant), 64'(rr_grant[i]));
    end

    // Randomised traffic against the model.
    #1;
    reset_dut();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (req[i]) req[i] = ($urandom_range(7) != 0);
        else        req[i] = ($urandom_range(3) == 0);
        set_px(i, int'($urandom_range(175)), int'($urandom_range(127)), 9'($urandom));
      end
      wr_en = 3'($urandom);
      step("rand");
    end

    // Clip counter saturation, then final write on the releasing cycle.
    #1;
    reset_dut();
    req = 3'b001;
    step("sat_grant");
    wr_en = 3'b001;
    set_px(0, 200, 0, 9'h111);
    for (int c = 0; c < 65537; c++) step("sat");
    chk("sat.clip_ffff", 64'(clip_count), 64'(16'hFFFF));
    set_px(0, 5, 6, 9'h123);
    req = 3'b000;
    step("final");
    chk("final.we",     64'(vga_WriteEn), 64'(1));
    chk("final.coords", 64'(vga_coords),  64'(pc(5, 6)));
    chk("final.colour", 64'(vga_colour),  64'(9'h123));
    chk("final.grant",  64'(grant),       64'(0));
    step("after_final");
    chk("after_final.we", 64'(vga_WriteEn), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
